ysyx_22040931_mem_arbiter: RTL and testbench
============================================

# ysyx_22040931_mem_arbiter

Two-requester arbiter and sequencer for the single core memory port. It shares the port between instruction fetch (IF) and the MEM-stage load/store path (LS). It latches each granted request, drives the request/response handshake toward memory, and routes the response back to its owner. It also generates byte write strobes from the size code and address offset, and rejects misaligned LS accesses without touching the bus.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, data width (strobe width = DATA_W/8)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- if_req_valid  input  1  fetch request (read, size D)
- if_req_addr  input  ADDR_W  fetch address
- if_req_ready  output  1  fetch request accepted this cycle
- if_rsp_valid  output  1  fetch data valid (one-cycle pulse)
- if_rsp_data  output  DATA_W  fetch data
- ls_req_valid  input  1  load/store request
- ls_req_wr  input  1  1 = store, 0 = load
- ls_req_size  input  2  SIZE_B/H/W/D = 00/01/10/11
- ls_req_addr  input  ADDR_W  byte address
- ls_req_wdata  input  DATA_W  store data, already lane-aligned
- ls_req_ready  output  1  LS request accepted or rejected this cycle
- ls_rsp_valid  output  1  load data returned or store completed (one-cycle pulse)
- ls_rsp_data  output  DATA_W  raw 64-bit load word
- ls_misalign  output  1  one-cycle pulse; LS request rejected as misaligned
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_wr  output  1  write flag
- mem_req_addr  output  ADDR_W  latched address
- mem_req_wdata  output  DATA_W  latched store data
- mem_req_wstrb  output  DATA_W/8  byte strobes, 0 on reads
- mem_rsp_valid  input  1  memory response
- mem_rsp_data  input  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any requester is valid, pick a winner, assert that requester's ready combinationally, latch the request, and go to REQ.
  - An LS request is rejected if misaligned: H with addr[0]≠0, W with addr[1:0]≠0, or D with addr[2:0]≠0. On rejection, ls_req_ready and ls_misalign pulse, nothing is latched, and the FSM stays in IDLE. IF may be granted in the same cycle.
- Arbitration: two-way round-robin. A `last` register records the previous grant (reset = IF). When both are valid, the requester not equal to `last` wins. When only one is valid, it wins. A rejected LS request does not update `last`.
- REQ: mem_req_valid = 1 with the latched fields. Fields are stable until mem_req_ready is seen. On mem_req_valid & mem_req_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid, forward it combinationally to the owner: rsp_valid = 1 and rsp_data = mem_rsp_data, then go to IDLE.
  - The non-owner's rsp_valid stays 0.
  - Store completion also uses mem_rsp_valid; ls_rsp_data is don't-care for stores.
- Strobes: base mask is B = 0x01, H = 0x03, W = 0x0F, D = 0xFF, shifted left by addr[2:0]. Strobes are forced to 0 for reads and for IF.
- Requester rule: hold valid and fields stable until ready. Dropping valid before ready is legal; the request is never seen.
- mem_rsp_valid in IDLE or REQ is ignored. This covers a stray response after reset.

## Timing
- Reset (async, immediate): state = IDLE, last = IF, latched fields = 0. All outputs are 0; this includes mem_req_valid, both ready signals, both rsp_valid signals, ls_misalign and wstrb.
- Reset mid-transaction abandons the transaction. No response is delivered for it.
- Minimum transaction: accept at cycle 0, mem_req_valid at cycle 1; with mem_req_ready = 1, WAIT at cycle 2; mem_rsp_valid at cycle 2 gives rsp_valid at cycle 2 and IDLE at cycle 3. Throughput is at most one transaction per 3 cycles.
- Back-pressure: mem_req_ready low holds REQ indefinitely with outputs unchanged.
- A misaligned rejection takes one cycle (ready and misalign in the same cycle).
- A new request is not accepted in the cycle a response is delivered.

## Structure
- Constants in the shared defines package: SIZE_B/H/W/D codes (already present) and FSM state encodings IDLE/REQ/WAIT.
- One sub-module: ysyx_22040931_wstrb_gen, combinational. Inputs: size, addr[2:0], wr. Outputs: wstrb[7:0] and misalign.
- Arbiter, FSM and latch registers live in the top module.

## Test plan
- IF-only: if_req_valid with addr 0x8000_0000, mem_req_ready = 1, response 0xDEAD_BEEF_0123_4567 one cycle later -> if_req_ready at c0, mem_req_valid at c1 with wstrb 0x00, if_rsp_valid and data at c2.
- Store byte: ls wr = 1, size B, addr 0x8000_0005 -> mem_req_wstrb = 0x20, mem_req_wr = 1; ls_rsp_valid pulses on mem_rsp_valid.
- Misaligned: ls size W, addr 0x8000_0002 -> ls_req_ready = 1 and ls_misalign = 1 in the same cycle; mem_req_valid stays 0; the FSM remains in IDLE.
- Contention: both valid continuously after reset -> grant order LS, IF, LS, IF; each response goes only to its owner.
- Back-pressure: mem_req_ready held low for 5 cycles -> mem_req_valid, addr, wdata and wstrb stay stable for all 5; accepted on the 6th.
- Reset mid-WAIT: assert rst in WAIT, then drive mem_rsp_valid after release -> no rsp_valid on either side, state is IDLE, all outputs 0.

Source files
------------

// File: rtl/ysyx_22040931_mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: access size codes, FSM states, requester ids.
// Pure definitions; no timing or flow-control behaviour of its own.
package ysyx_22040931_mem_arbiter_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         SIZE_B:  m = 8'h01;
         SIZE_H:  m = 8'h03;
         SIZE_W:  m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ysyx_22040931_wstrb_gen.sv
// Byte-strobe and alignment check for one LS access; purely combinational, zero latency.
// No flow control: outputs follow size/addr/wr in the same cycle.
module ysyx_22040931_wstrb_gen
   import ysyx_22040931_mem_arbiter_pkg::*;
(
   input  logic [1:0] size,
   input  logic [2:0] addr,
   input  logic       wr,
   output logic [7:0] wstrb,
   output logic       misalign
);

   always_comb begin
      misalign = 1'b0;
      case (size)
         SIZE_H:  misalign = addr[0];
         SIZE_W:  misalign = |addr[1:0];
         SIZE_D:  misalign = |addr;
         default: misalign = 1'b0;
      endcase
   end

   assign wstrb = wr ? (size_mask(size) << addr) : 8'h00;

endmodule

// File: rtl/ysyx_22040931_mem_arbiter.sv
// Round-robin IF/LS arbiter sequencing one memory transaction at a time (accept c0, request c1, earliest response c2).
// mem_req_ready low parks the latched request in REQ unchanged; requesters wait for ready; misaligned LS is rejected in one cycle.
module ysyx_22040931_mem_arbiter
   import ysyx_22040931_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_valid,
   input  logic [ADDR_W-1:0]     if_req_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [DATA_W-1:0]     if_rsp_data,
   input  logic                  ls_req_valid,
   input  logic                  ls_req_wr,
   input  logic [1:0]            ls_req_size,
   input  logic [ADDR_W-1:0]     ls_req_addr,
   input  logic [DATA_W-1:0]     ls_req_wdata,
   output logic                  ls_req_ready,
   output logic                  ls_rsp_valid,
   output logic [DATA_W-1:0]     ls_rsp_data,
   output logic                  ls_misalign,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_wr,
   output logic [ADDR_W-1:0]     mem_req_addr,
   output logic [DATA_W-1:0]     mem_req_wdata,
   output logic [DATA_W/8-1:0]   mem_req_wstrb,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rsp_data
);

   localparam int STRB_W = DATA_W / 8;

   typedef struct packed {
      owner_t              owner;
      logic                wr;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic [7:0]          wstrb;
   } req_t;

   state_t     state_q, state_d;
   owner_t     last_q, last_d;
   req_t       req_q, req_d;
   logic [7:0] ls_wstrb;
   logic       ls_bad;
   logic       ls_ok;
   logic       grant_if;
   logic       grant_ls;

   ysyx_22040931_wstrb_gen u_wstrb_gen (
      .size     (ls_req_size),
      .addr     (ls_req_addr[2:0]),
      .wr       (ls_req_wr),
      .wstrb    (ls_wstrb),
      .misalign (ls_bad)
   );

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      req_d        = req_q;
      ls_ok        = 1'b0;
      grant_if     = 1'b0;
      grant_ls     = 1'b0;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      ls_misalign  = 1'b0;
      if_rsp_valid = 1'b0;
      ls_rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst so every output reads 0 while reset is held.
            if (!rst) begin
               ls_ok = ls_req_valid & ~ls_bad;
               if (if_req_valid && ls_ok) begin
                  grant_ls = (last_q == OWN_IF);
                  grant_if = ~grant_ls;
               end else begin
                  grant_if = if_req_valid;
                  grant_ls = ls_ok;
               end
               ls_misalign  = ls_req_valid & ls_bad;
               if_req_ready = grant_if;
               ls_req_ready = grant_ls | ls_misalign;
               if (grant_if) begin
                  req_d.owner = OWN_IF;
                  req_d.wr    = 1'b0;
                  req_d.addr  = if_req_addr;
                  req_d.wdata = '0;
                  req_d.wstrb = 8'h00;
                  last_d      = OWN_IF;
                  state_d     = REQ;
               end else if (grant_ls) begin
                  req_d.owner = OWN_LS;
                  req_d.wr    = ls_req_wr;
                  req_d.addr  = ls_req_addr;
                  req_d.wdata = ls_req_wdata;
                  req_d.wstrb = ls_wstrb;
                  last_d      = OWN_LS;
                  state_d     = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               if_rsp_valid = (req_q.owner == OWN_IF);
               ls_rsp_valid = (req_q.owner == OWN_LS);
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= OWN_IF;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         req_q   <= req_d;
      end
   end

   assign mem_req_valid = (state_q == REQ);
   assign mem_req_wr    = req_q.wr;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;
   assign mem_req_wstrb = STRB_W'(req_q.wstrb);
   assign if_rsp_data   = if_rsp_valid ? mem_rsp_data : '0;
   assign ls_rsp_data   = ls_rsp_valid ? mem_rsp_data : '0;

endmodule

// File: tb/tb_ysyx_22040931_mem_arbiter.sv
// Directed self-checking bench for ysyx_22040931_mem_arbiter.
module tb_ysyx_22040931_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_valid;
   logic [63:0] if_req_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [63:0] if_rsp_data;
   logic        ls_req_valid;
   logic        ls_req_wr;
   logic [1:0]  ls_req_size;
   logic [63:0] ls_req_addr;
   logic [63:0] ls_req_wdata;
   logic        ls_req_ready;
   logic        ls_rsp_valid;
   logic [63:0] ls_rsp_data;
   logic        ls_misalign;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wr;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22040931_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .ls_req_valid(ls_req_valid), .ls_req_wr(ls_req_wr), .ls_req_size(ls_req_size),
      .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_misalign(ls_misalign),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
   );

   // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if_req_valid  = 1'b0;
      if_req_addr   = '0;
      ls_req_valid  = 1'b0;
      ls_req_wr     = 1'b0;
      ls_req_size   = 2'b00;
      ls_req_addr   = '0;
      ls_req_wdata  = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
      ls_req_valid = 1'b1; ls_req_size = 2'b11; ls_req_addr = 64'h8000_0008;
      mem_rsp_valid = 1'b1; mem_rsp_data = '1; mem_req_ready = 1'b1;
      #1;
      checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready: got %b want 0", if_req_ready); end
      checks++; if (ls_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ls_ready: got %b want 0", ls_req_ready); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b want 0", mem_req_valid); end
      checks++; if ({if_rsp_valid, ls_rsp_valid, ls_misalign} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {if_rsp_valid, ls_rsp_valid, ls_misalign}); end
      checks++; if (mem_req_wstrb !== 8'h00 || mem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_fields: got wstrb %h addr %h want 0", mem_req_wstrb, mem_req_addr); end
      checks++; if (if_rsp_data !== 64'h0 || ls_rsp_data !== 64'h0) begin errors++; $display("FAIL rst_rsp_data: got %h %h want 0", if_rsp_data, ls_rsp_data); end
      step(); step();
      clear_inputs();
      rst = 1'b0;
      step();
   endtask

   task automatic test_if_only();
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0000; mem_req_ready = 1'b1;
      #1;
      checks++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin errors++; $display("FAIL if_c0_ready: got if %b ls %b want 1 0", if_req_ready, ls_req_ready); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL if_c0_memvalid: got %b want 0", mem_req_valid); end
      step();
      if_req_valid = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL if_c1_req: got v %b addr %h want 1 80000000", mem_req_valid, mem_req_addr); end
      checks++; if (mem_req_wstrb !== 8'h00 || mem_req_wr !== 1'b0) begin errors++; $display("FAIL if_c1_wstrb: got %h wr %b want 00 0", mem_req_wstrb, mem_req_wr); end
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD_BEEF_0123_4567;
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0040;
      #1;
      checks++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL if_c2_rsp: got v %b data %h want 1 deadbeef01234567", if_rsp_valid, if_rsp_data); end
      checks++; if (ls_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL if_c2_other: got ls_rsp %b memv %b want 0 0", ls_rsp_valid, mem_req_valid); end
      checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL if_c2_noaccept: got %b want 0", if_req_ready); end
      step();
      clear_inputs();
      #1;
      checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL if_c3_pulse: got %b want 0", if_rsp_valid); end
      step();
   endtask

   task automatic test_store_byte();
      ls_req_valid = 1'b1; ls_req_wr = 1'b1; ls_req_size = 2'b00;
      ls_req_addr = 64'h8000_0005; ls_req_wdata = 64'h0000_AB00_0000_0000; mem_req_ready = 1'b1;
      #1;
      checks++; if (ls_req_ready !== 1'b1 || ls_misalign !== 1'b0) begin errors++; $display("FAIL sb_c0_ready: got %b mis %b want 1 0", ls_req_ready, ls_misalign); end
      step();
      ls_req_valid = 1'b0;
      #1;
      checks++; if (mem_req_wstrb !== 8'h20 || mem_req_wr !== 1'b1) begin errors++; $display("FAIL sb_c1_wstrb: got %h wr %b want 20 1", mem_req_wstrb, mem_req_wr); end
      checks++; if (mem_req_addr !== 64'h8000_0005 || mem_req_wdata !== 64'h0000_AB00_0000_0000) begin errors++; $display("FAIL sb_c1_fields: got %h %h", mem_req_addr, mem_req_wdata); end
      step();
      mem_rsp_valid = 1'b1;
      #1;
      checks++; if (ls_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0) begin errors++; $display("FAIL sb_c2_rsp: got ls %b if %b want 1 0", ls_rsp_valid, if_rsp_valid); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_misalign();
      ls_req_valid = 1'b1; ls_req_size = 2'b10; ls_req_addr = 64'h8000_0002;
      #1;
      checks++; if (ls_req_ready !== 1'b1 || ls_misalign !== 1'b1) begin errors++; $display("FAIL mis_w_pulse: got rdy %b mis %b want 1 1", ls_req_ready, ls_misalign); end
      step();
      ls_req_valid = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0 || ls_misalign !== 1'b0) begin errors++; $display("FAIL mis_w_nobus: got memv %b mis %b want 0 0", mem_req_valid, ls_misalign); end
      // Still idle: IF is granted at once while a misaligned halfword is rejected alongside it.
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
      ls_req_valid = 1'b1; ls_req_size = 2'b01; ls_req_addr = 64'h8000_0011;
      mem_req_ready = 1'b1;
      #1;
      checks++; if ({if_req_ready, ls_req_ready, ls_misalign} !== 3'b111) begin errors++; $display("FAIL mis_h_with_if: got %b want 111", {if_req_ready, ls_req_ready, ls_misalign}); end
      step();
      clear_inputs(); mem_req_ready = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL mis_if_req: got %b %h want 1 80000100", mem_req_valid, mem_req_addr); end
      step();
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'h55;
      #1;
      checks++; if (if_rsp_valid !== 1'b1 || ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL mis_if_rsp: got if %b ls %b want 1 0", if_rsp_valid, ls_rsp_valid); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_contention();
      logic        exp_ls;
      logic [63:0] rdata;
      logic [63:0] exp_addr;
      rst = 1'b1; #1; rst = 1'b0;
      step();
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
      ls_req_valid = 1'b1; ls_req_wr = 1'b0; ls_req_size = 2'b11; ls_req_addr = 64'h8000_1000;
      mem_req_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_ls   = (t % 2 == 0);
         exp_addr = exp_ls ? 64'h8000_1000 : 64'h8000_0200;
         rdata    = 64'hC0DE_0000_0000_0000 + 64'(t);
         mem_rsp_valid = 1'b0;
         #1;
         checks++; if (ls_req_ready !== exp_ls || if_req_ready !== !exp_ls) begin errors++; $display("FAIL cont_grant%0d: got ls %b if %b want ls %b", t, ls_req_ready, if_req_ready, exp_ls); end
         step();
         #1;
         checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || mem_req_wstrb !== 8'h00) begin errors++; $display("FAIL cont_req%0d: got v %b addr %h strb %h want addr %h", t, mem_req_valid, mem_req_addr, mem_req_wstrb, exp_addr); end
         step();
         mem_rsp_valid = 1'b1; mem_rsp_data = rdata;
         #1;
         checks++; if (ls_rsp_valid !== exp_ls || if_rsp_valid !== !exp_ls) begin errors++; $display("FAIL cont_rsp%0d: got ls %b if %b want ls %b", t, ls_rsp_valid, if_rsp_valid, exp_ls); end
         checks++; if ((exp_ls ? ls_rsp_data : if_rsp_data) !== rdata) begin errors++; $display("FAIL cont_data%0d: got %h want %h", t, exp_ls ? ls_rsp_data : if_rsp_data, rdata); end
         checks++; if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin errors++; $display("FAIL cont_norecept%0d: got if %b ls %b want 0 0", t, if_req_ready, ls_req_ready); end
         step();
      end
      clear_inputs();
      step();
   endtask

   task automatic test_back_pressure();
      ls_req_valid = 1'b1; ls_req_wr = 1'b1; ls_req_size = 2'b01;
      ls_req_addr = 64'h8000_0306; ls_req_wdata = 64'hBEEF_0000_0000_0000;
      #1;
      checks++; if (ls_req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", ls_req_ready); end
      step();
      clear_inputs();
      for (int c = 0; c < 5; c++) begin
         mem_rsp_valid = (c == 2);
         #1;
         checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0306 || mem_req_wdata !== 64'hBEEF_0000_0000_0000 || mem_req_wstrb !== 8'hC0) begin errors++; $display("FAIL bp_hold%0d: got v %b addr %h wd %h strb %h", c, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb); end
         checks++; if (ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_stray_rsp%0d: got %b want 0", c, ls_rsp_valid); end
         step();
      end
      mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_sixth: got %b want 1", mem_req_valid); end
      step();
      mem_req_ready = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_wait: got %b want 0", mem_req_valid); end
      mem_rsp_valid = 1'b1;
      #1;
      checks++; if (ls_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp: got %b want 1", ls_rsp_valid); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_reset_mid_wait();
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0400; mem_req_ready = 1'b1;
      step();
      if_req_valid = 1'b0;
      step();
      #1;
      checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h8000_0400) begin errors++; $display("FAIL rw_inwait: got v %b addr %h", mem_req_valid, mem_req_addr); end
      rst = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234;
      #1;
      checks++; if (if_rsp_valid !== 1'b0 || mem_req_addr !== 64'h0) begin errors++; $display("FAIL rw_async: got rsp %b addr %h want 0 0", if_rsp_valid, mem_req_addr); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL rw_norsp: got if %b ls %b want 0 0", if_rsp_valid, ls_rsp_valid); end
      checks++; if (mem_req_valid !== 1'b0 || mem_req_wstrb !== 8'h00 || mem_req_wr !== 1'b0 || mem_req_wdata !== 64'h0) begin errors++; $display("FAIL rw_outputs: got v %b strb %h wr %b wd %h", mem_req_valid, mem_req_wstrb, mem_req_wr, mem_req_wdata); end
      step();
      mem_rsp_valid = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0500;
      #1;
      checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL rw_idle: got %b want 1", if_req_ready); end
      step();
      clear_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_if_only();
      test_store_byte();
      test_misalign();
      test_contention();
      test_back_pressure();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
